// File: rtl/lcd_cmd_ctrl.sv
// lcd_cmd_ctrl: turns toggled LCD words from the LSU into HD44780-style parallel write cycles
module lcd_cmd_ctrl #(
   parameter int SETUP_CYC    = 4,
   parameter int EN_CYC       = 12,
   parameter int HOLD_CYC     = 2,
   parameter int CMD_WAIT_CYC = 2500,
   parameter int CLR_WAIT_CYC = 82000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] lcd_word_i,
   output logic        lcd_on_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o,
   output logic        busy_o,
   output logic        ovf_o
);
   localparam int W = $clog2(CLR_WAIT_CYC + 1);
   localparam logic [W-1:0] SETUP_L = W'(SETUP_CYC);
   localparam logic [W-1:0] EN_L    = W'(EN_CYC);
   localparam logic [W-1:0] HOLD_L  = W'(HOLD_CYC);
   localparam logic [W-1:0] CMD_L   = W'(CMD_WAIT_CYC);
   localparam logic [W-1:0] CLR_L   = W'(CLR_WAIT_CYC);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d, cnt_dec;
   logic         tog_q, tog_d;
   logic         on_q, on_d;
   logic         rs_q, rs_d;
   logic [7:0]   data_q, data_d;
   logic         en_q, en_d;
   logic         busy_q, busy_d;
   logic         ovf_q, ovf_d;
   logic         pv_q, pv_d;
   logic         prs_q, prs_d;
   logic [7:0]   pdata_q, pdata_d;
   logic         toggle, done, clr, wait_exit, take, launch, use_p, l_rs;
   logic [7:0]   l_data;
   logic         unused_bits;
   assign unused_bits = ^{lcd_word_i[30:11], lcd_word_i[8]};
   assign lcd_on_o   = on_q;
   assign lcd_rs_o   = rs_q;
   assign lcd_rw_o   = 1'b0;
   assign lcd_en_o   = en_q;
   assign lcd_data_o = data_q;
   assign busy_o     = busy_q;
   assign ovf_o      = ovf_q;
   // next-state: command capture, pending slot, timing FSM and registered pin values
   always_comb begin
      toggle    = lcd_word_i[10] != tog_q;
      done      = cnt_q == W'(1);
      cnt_dec   = cnt_q - W'(1);
      clr       = !rs_q && data_q[7:2] == 6'd0;
      wait_exit = state_q == S_WAIT && done;
      take      = toggle && state_q != S_IDLE && !(wait_exit && !pv_q);
      launch    = (state_q == S_IDLE && toggle) || (wait_exit && (pv_q || toggle));
      use_p     = wait_exit && pv_q;
      l_rs      = use_p ? prs_q : lcd_word_i[9];
      l_data    = use_p ? pdata_q : lcd_word_i[7:0];
      tog_d     = lcd_word_i[10];
      on_d      = lcd_word_i[31];
      pv_d      = take || (pv_q && !wait_exit);
      prs_d     = take ? lcd_word_i[9] : prs_q;
      pdata_d   = take ? lcd_word_i[7:0] : pdata_q;
      ovf_d     = ovf_q || (take && pv_q && !wait_exit);
      state_d   = state_q;
      cnt_d     = cnt_q;
      rs_d      = rs_q;
      data_d    = data_q;
      case (state_q)
         S_SETUP: begin
            state_d = done ? S_PULSE : S_SETUP;
            cnt_d   = done ? EN_L : cnt_dec;
         end
         S_PULSE: begin
            state_d = done ? S_HOLD : S_PULSE;
            cnt_d   = done ? HOLD_L : cnt_dec;
         end
         S_HOLD: begin
            state_d = done ? S_WAIT : S_HOLD;
            cnt_d   = done ? (clr ? CLR_L : CMD_L) : cnt_dec;
         end
         S_WAIT: begin
            state_d = done ? S_IDLE : S_WAIT;
            cnt_d   = done ? '0 : cnt_dec;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      if (launch) begin
         state_d = S_SETUP;
         cnt_d   = SETUP_L;
         rs_d    = l_rs;
         data_d  = l_data;
      end
      en_d   = state_d == S_PULSE;
      busy_d = state_d != S_IDLE;
   end
   // state registers; reset drops EN immediately and discards any command in flight
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tog_q   <= 1'b0;
         on_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'd0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         pv_q    <= 1'b0;
         prs_q   <= 1'b0;
         pdata_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tog_q   <= tog_d;
         on_q    <= on_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         pv_q    <= pv_d;
         prs_q   <= prs_d;
         pdata_q <= pdata_d;
      end
   end
endmodule

// File: tb/tb_lcd_cmd_ctrl.sv
// tb_lcd_cmd_ctrl: directed checks of LCD write timing, pending/overflow handling and reset
module tb_lcd_cmd_ctrl;
   typedef struct {int at; logic rs; logic [7:0] d;} inj_t;
   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [31:0] lcd_word_i = 32'h8000_07FF;
   logic        lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, busy_o, ovf_o;
   logic [7:0]  lcd_data_o;
   int          n_vec = 0;
   int          n_miss = 0;
   logic        tog = 1'b1;
   logic        on = 1'b1;
   logic        en_prev = 1'b0;
   logic [8:0]  wlog[$];
   inj_t        inj[$];
   int          rq[$];
   int          busy_n;
   int          base;
   lcd_cmd_ctrl #(
      .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(1), .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .lcd_word_i(lcd_word_i), .lcd_on_o(lcd_on_o),
      .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_en_o(lcd_en_o), .lcd_data_o(lcd_data_o),
      .busy_o(busy_o), .ovf_o(ovf_o)
   );
   always #5 clk_i = ~clk_i;
   // log {RS, DATA} of every EN pulse as the LCD would latch it
   always @(negedge clk_i) begin
      if (lcd_en_o && !en_prev) wlog.push_back({lcd_rs_o, lcd_data_o});
      en_prev = lcd_en_o;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic send(input logic rs, input logic [7:0] d);
      tog = ~tog;
      lcd_word_i = {on, 20'd0, tog, rs, 1'b0, d};
   endtask
   task automatic add_inj(input int at, input logic rs, input logic [7:0] d);
      inj_t e;
      e.at = at; e.rs = rs; e.d = d;
      inj.push_back(e);
   endtask
   task automatic measure();
      logic pe = 1'b0;
      logic fin = 1'b0;
      busy_n = 0;
      rq.delete();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_i);
         if (busy_o) busy_n++;
         else if (busy_n > 0) begin
            fin = 1'b1;
            break;
         end
         if (lcd_en_o && !pe) rq.push_back(i);
         pe = lcd_en_o;
         foreach (inj[k]) if (inj[k].at == i) send(inj[k].rs, inj[k].d);
      end
      inj.delete();
      chk("idle_reached", {31'd0, fin}, 1);
   endtask
   function automatic logic [31:0] rise(input int k);
      return rq.size() > k ? rq[k] : 32'hFFFF_FFFF;
   endfunction
   function automatic logic [31:0] wr(input int k);
      return wlog.size() > k ? {23'd0, wlog[k]} : 32'hFFFF_FFFF;
   endfunction
   task automatic one_cmd(input string tag, input logic rs, input logic [7:0] d, input int exp_busy);
      base = wlog.size();
      send(rs, d);
      measure();
      chk({tag, "_busy"}, busy_n, exp_busy);
      chk({tag, "_wr"}, wr(base), {23'd0, rs, d});
   endtask
   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_outs", {lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, busy_o, ovf_o, lcd_data_o}, 0);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("rel_on", lcd_on_o, 1);
      chk("rel_busy", busy_o, 1);
      chk("rel_cmd", {lcd_rs_o, lcd_data_o}, 9'h1FF);
      chk("rel_en", lcd_en_o, 0);
      measure();
      chk("rel_busy_rest", busy_n, 10);
      chk("rel_rise", rise(0), 1);
      base = wlog.size();
      send(1'b1, 8'h41);
      measure();
      chk("wr_busy", busy_n, 11);
      chk("wr_rise", rise(0), 2);
      chk("wr_nrise", rq.size(), 1);
      chk("wr_pins", {lcd_rs_o, lcd_rw_o, lcd_data_o}, {1'b1, 1'b0, 8'h41});
      chk("wr_log", wr(base), 9'h141);
      one_cmd("clr01", 1'b0, 8'h01, 26);
      one_cmd("home02", 1'b0, 8'h02, 26);
      one_cmd("fn38", 1'b0, 8'h38, 11);
      one_cmd("mode04", 1'b0, 8'h04, 11);
      one_cmd("dat01", 1'b1, 8'h01, 11);
      base = wlog.size();
      send(1'b1, 8'h50);
      add_inj(2, 1'b1, 8'h42);
      measure();
      chk("pend_busy", busy_n, 22);
      chk("pend_rise1", rise(1), 13);
      chk("pend_wrA", wr(base), 9'h150);
      chk("pend_wrB", wr(base + 1), 9'h142);
      chk("pend_ovf", ovf_o, 0);
      base = wlog.size();
      send(1'b1, 8'h61);
      add_inj(2, 1'b1, 8'h62);
      add_inj(10, 1'b1, 8'h63);
      measure();
      chk("edge_busy", busy_n, 33);
      chk("edge_rise2", rise(2), 24);
      chk("edge_wrB", wr(base + 1), 9'h162);
      chk("edge_wrC", wr(base + 2), 9'h163);
      chk("edge_ovf", ovf_o, 0);
      base = wlog.size();
      send(1'b1, 8'h71);
      add_inj(10, 1'b0, 8'h80);
      measure();
      chk("direct_busy", busy_n, 22);
      chk("direct_rise1", rise(1), 13);
      chk("direct_wrC", wr(base + 1), 9'h080);
      base = wlog.size();
      send(1'b1, 8'hA1);
      add_inj(0, 1'b1, 8'hB2);
      add_inj(1, 1'b1, 8'hC3);
      measure();
      chk("ovf_busy", busy_n, 22);
      chk("ovf_nwr", wlog.size() - base, 2);
      chk("ovf_wrA", wr(base), 9'h1A1);
      chk("ovf_wrC", wr(base + 1), 9'h1C3);
      chk("ovf_flag", ovf_o, 1);
      one_cmd("sticky", 1'b1, 8'h33, 11);
      chk("ovf_sticky", ovf_o, 1);
      on = 1'b0;
      lcd_word_i[31] = 1'b0;
      @(negedge clk_i);
      chk("on_low", {lcd_on_o, busy_o}, 0);
      on = 1'b1;
      lcd_word_i[31] = 1'b1;
      @(negedge clk_i);
      chk("on_high", lcd_on_o, 1);
      base = wlog.size();
      send(1'b1, 8'h55);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (lcd_en_o) break;
      end
      chk("ar_en_seen", lcd_en_o, 1);
      send(1'b1, 8'h66);
      @(negedge clk_i);
      #2 rst_n_i = 1'b0;
      #1;
      chk("ar_en", lcd_en_o, 0);
      chk("ar_outs", {busy_o, ovf_o, lcd_on_o, lcd_rs_o, lcd_data_o}, 0);
      tog = 1'b0;
      lcd_word_i = {on, 20'd0, tog, 1'b1, 1'b0, 8'h77};
      @(negedge clk_i);
      rst_n_i = 1'b1;
      busy_n = 0;
      repeat (30) begin
         @(negedge clk_i);
         if (busy_o) busy_n++;
      end
      chk("ar_idle", busy_n, 0);
      chk("ar_nwr", wlog.size() - base, 1);
      chk("ar_on", lcd_on_o, 1);
      one_cmd("post_rst", 1'b1, 8'h99, 11);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
